// File: rtl/moving_average_pkg.sv
// ---------------------------------------------------------------------------
// moving_average_pkg
// Shared definitions for the multi-channel moving-average filter:
//   - state_t     : control FSM states (IDLE, UPD, OUT)
//   - sumWidth    : width of a channel's running sum
//   - chWidth     : width of a channel index
//   - wpWidth     : width of a delay-line write pointer
//   - winWidth    : width of the run-time window exponent
//   - roundShift  : divide a running sum by 2^win with optional round-half-up
// ---------------------------------------------------------------------------
package moving_average_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int sumWidth(input int dataW, input int winPowMax);
        return dataW + winPowMax;
    endfunction

    function automatic int chWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int wpWidth(input int winPowMax);
        return (winPowMax > 0) ? winPowMax : 1;
    endfunction

    function automatic int winWidth(input int winPowMax);
        return (winPowMax > 0) ? $clog2(winPowMax + 1) : 1;
    endfunction

    // Evaluated at 32 bits, which always covers the SUM_W+1 bits needed so
    // that adding the half-LSB bias to a full-scale sum cannot overflow.
    function automatic logic [31:0] roundShift(input logic [31:0] sum,
                                               input logic [31:0] win,
                                               input logic        rnd);
        logic [31:0] bias;
        bias = 32'd0;
        if (rnd && (win != 32'd0)) begin
            bias = 32'd1 << (win - 32'd1);
        end
        return (sum + bias) >> win;
    endfunction

endpackage

// File: rtl/moving_average_mc_buf.sv
// ---------------------------------------------------------------------------
// ma_channel_buf
// Storage and running sum for one filter channel. Holds a delay line of
// 2^WIN_POW_MAX samples, a write pointer that wraps at 2^win-1, an O(1)
// running sum and a fill counter that saturates at 2^win.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_clear     : synchronous flush of all channel state
//   i_win       : active window exponent (stable between clears)
//   i_we        : accept i_data into the window this cycle
//   i_data      : new sample
//   o_sum       : running sum of the last 2^win samples (zero pre-fill)
//   o_full      : at least 2^win samples written since clear/reset
// ---------------------------------------------------------------------------
module ma_channel_buf
    import moving_average_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int WIN_POW_MAX = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     i_clear,
    input  logic [winWidth(WIN_POW_MAX)-1:0]         i_win,
    input  logic                                     i_we,
    input  logic [DATA_W-1:0]                        i_data,
    output logic [sumWidth(DATA_W, WIN_POW_MAX)-1:0] o_sum,
    output logic                                     o_full
);

    localparam int SUM_W  = sumWidth(DATA_W, WIN_POW_MAX);
    localparam int WP_W   = wpWidth(WIN_POW_MAX);
    localparam int DEPTH  = 1 << WIN_POW_MAX;
    localparam int FILL_W = WIN_POW_MAX + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [WP_W-1:0]   r_ptr;
    logic [SUM_W-1:0]  r_sum;
    logic [FILL_W-1:0] r_fill;

    logic [WP_W-1:0]   w_ptrMask;
    logic [FILL_W-1:0] w_fillTarget;
    logic [DATA_W-1:0] w_oldest;

    assign w_ptrMask    = WP_W'((32'd1 << i_win) - 32'd1);
    assign w_fillTarget = FILL_W'(32'd1 << i_win);
    // The slot about to be overwritten holds the sample that leaves the window.
    assign w_oldest     = r_mem[r_ptr];

    // Replace the oldest sample and adjust the sum by the difference, so the
    // sum always equals the total of the delay-line slots currently in use.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr  <= '0;
            r_sum  <= '0;
            r_fill <= '0;
        end else if (i_we) begin
            r_mem[r_ptr] <= i_data;
            r_sum        <= r_sum + SUM_W'(i_data) - SUM_W'(w_oldest);
            r_ptr        <= (r_ptr == w_ptrMask) ? '0 : r_ptr + WP_W'(1);
            if (r_fill != w_fillTarget) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_full = (r_fill == w_fillTarget);

endmodule

// File: rtl/moving_average_mc.sv
// ---------------------------------------------------------------------------
// moving_average_mc
// Multi-channel, time-multiplexed moving-average filter with a run-time
// power-of-two window, optional round-half-up and a valid/ready input.
// A sample takes three cycles: IDLE (accept), UPD (window update), OUT
// (result registered and strobed).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clear_i      : flush all channels and load win_pow_i (clamped)
//   win_pow_i    : log2 of the window, sampled only with clear_i
//   in_valid_i   : sample offered
//   in_ready_o   : block can accept a sample (IDLE)
//   in_data_i    : sample value
//   in_ch_i      : channel of the sample; out-of-range channels are dropped
//   round_i      : 1 = round half up, 0 = truncate; sampled at accept
//   out_valid_o  : one-cycle result strobe
//   out_data_o   : average, held until the next strobe
//   out_ch_o     : channel of out_data_o
//   out_full_o   : that channel has seen at least 2^win samples
// ---------------------------------------------------------------------------
module moving_average_mc
    import moving_average_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int WIN_POW_MAX = 3,
    parameter int CHANNELS    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_i,
    input  logic [winWidth(WIN_POW_MAX)-1:0] win_pow_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [DATA_W-1:0]                in_data_i,
    input  logic [chWidth(CHANNELS)-1:0]     in_ch_i,
    input  logic                             round_i,
    output logic                             out_valid_o,
    output logic [DATA_W-1:0]                out_data_o,
    output logic [chWidth(CHANNELS)-1:0]     out_ch_o,
    output logic                             out_full_o
);

    localparam int SUM_W = sumWidth(DATA_W, WIN_POW_MAX);
    localparam int CH_W  = chWidth(CHANNELS);
    localparam int WIN_W = winWidth(WIN_POW_MAX);

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_ch;
    logic              r_round;
    logic [WIN_W-1:0]  r_winPow;
    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [CH_W-1:0]   r_outCh;
    logic              r_outFull;

    logic [CHANNELS-1:0] w_chHit;
    logic [CHANNELS-1:0] w_we;
    logic [CHANNELS-1:0] w_full;
    logic [SUM_W-1:0]    w_sum [CHANNELS];
    logic [SUM_W-1:0]    w_selSum;
    logic                w_selFull;
    logic                w_chValid;
    logic [WIN_W-1:0]    w_winClamped;
    logic [DATA_W-1:0]   w_avg;

    assign w_winClamped = (32'(win_pow_i) > WIN_POW_MAX) ? WIN_W'(WIN_POW_MAX)
                                                         : win_pow_i;

    // Per-channel storage; only the latched channel is written, and only in UPD.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign w_chHit[c] = (r_ch == CH_W'(c));
        assign w_we[c]    = (r_state == UPD) && w_chHit[c] && !clear_i;

        ma_channel_buf #(
            .DATA_W      (DATA_W),
            .WIN_POW_MAX (WIN_POW_MAX)
        ) u_buf (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (clear_i),
            .i_win   (r_winPow),
            .i_we    (w_we[c]),
            .i_data  (r_data),
            .o_sum   (w_sum[c]),
            .o_full  (w_full[c])
        );
    end

    // Channel mux built from the decode hits so that an out-of-range channel
    // index simply selects nothing and reports itself as invalid.
    always_comb begin
        w_selSum  = '0;
        w_selFull = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_chHit[c]) begin
                w_selSum  = w_sum[c];
                w_selFull = w_full[c];
            end
        end
    end

    assign w_chValid = |w_chHit;
    assign w_avg     = DATA_W'(roundShift(32'(w_selSum), 32'(r_winPow), r_round));

    // Control FSM and output registers. clear_i beats everything but reset and
    // also kills a strobe that would otherwise have been issued from OUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_ch       <= '0;
            r_round    <= 1'b0;
            r_winPow   <= WIN_W'(WIN_POW_MAX);
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_outFull  <= 1'b0;
        end else if (clear_i) begin
            r_state    <= IDLE;
            r_winPow   <= w_winClamped;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_outFull  <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_data  <= in_data_i;
                        r_ch    <= in_ch_i;
                        r_round <= round_i;
                        r_state <= UPD;
                    end
                end
                UPD: begin
                    r_state <= w_chValid ? OUT : IDLE;
                end
                OUT: begin
                    r_outData  <= w_avg;
                    r_outCh    <= r_ch;
                    r_outFull  <= w_selFull;
                    r_outValid <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = (r_state == IDLE);
    assign out_valid_o = r_outValid;
    assign out_data_o  = r_outData;
    assign out_ch_o    = r_outCh;
    assign out_full_o  = r_outFull;

endmodule

// File: tb/tb_moving_average_mc.sv
// ---------------------------------------------------------------------------
// tb_moving_average_mc
// Directed and random stimulus for moving_average_mc (DATA_W=8,
// WIN_POW_MAX=2, CHANNELS=2), plus a single-channel instance used to show
// that samples on a non-existent channel are dropped. Expected averages come
// from a per-channel history of accepted samples.
// ---------------------------------------------------------------------------
module tb_moving_average_mc;

    localparam int DATA_W      = 8;
    localparam int WIN_POW_MAX = 2;
    localparam int CHANNELS    = 2;

    logic       clk;
    logic       rst_n;
    logic       clear_i;
    logic [1:0] win_pow_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] in_data_i;
    logic [0:0] in_ch_i;
    logic       round_i;
    logic       out_valid_o;
    logic [7:0] out_data_o;
    logic [0:0] out_ch_o;
    logic       out_full_o;

    logic       sValid;
    logic       sReady;
    logic [7:0] sData;
    logic [0:0] sCh;
    logic       sClear;
    logic [1:0] sWin;
    logic       sRound;
    logic       sOutValid;
    logic [7:0] sOutData;
    logic [0:0] sOutCh;
    logic       sOutFull;

    int checks = 0;
    int errors = 0;
    int hist [CHANNELS][$];
    int modelWin;
    int lastData;

    moving_average_mc #(
        .DATA_W      (DATA_W),
        .WIN_POW_MAX (WIN_POW_MAX),
        .CHANNELS    (CHANNELS)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_i),
        .win_pow_i   (win_pow_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_ch_i     (in_ch_i),
        .round_i     (round_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ch_o    (out_ch_o),
        .out_full_o  (out_full_o)
    );

    moving_average_mc #(
        .DATA_W      (DATA_W),
        .WIN_POW_MAX (WIN_POW_MAX),
        .CHANNELS    (1)
    ) u_single (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (sClear),
        .win_pow_i   (sWin),
        .in_valid_i  (sValid),
        .in_ready_o  (sReady),
        .in_data_i   (sData),
        .in_ch_i     (sCh),
        .round_i     (sRound),
        .out_valid_o (sOutValid),
        .out_data_o  (sOutData),
        .out_ch_o    (sOutCh),
        .out_full_o  (sOutFull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelClear(input int w);
        for (int c = 0; c < CHANNELS; c++) hist[c].delete();
        modelWin = (w > WIN_POW_MAX) ? WIN_POW_MAX : w;
        lastData = 0;
    endtask

    // Average of the most recent 2^win samples, missing samples counting as 0.
    function automatic int modelAverage(input int ch, input logic rnd);
        int n;
        int sum;
        int first;
        n     = 1 << modelWin;
        sum   = 0;
        first = (hist[ch].size() > n) ? hist[ch].size() - n : 0;
        for (int i = first; i < hist[ch].size(); i++) sum += hist[ch][i];
        if (rnd && modelWin > 0) sum += n / 2;
        return sum / n;
    endfunction

    function automatic logic modelFull(input int ch);
        return hist[ch].size() >= (1 << modelWin);
    endfunction

    task automatic doClear(input int w);
        clear_i   = 1'b1;
        win_pow_i = w[1:0];
        @(posedge clk); #1;
        clear_i = 1'b0;
        modelClear(w);
        checkOutput("clr/valid", out_valid_o, 0);
        checkOutput("clr/data", out_data_o, 0);
        checkOutput("clr/ch", out_ch_o, 0);
        checkOutput("clr/full", out_full_o, 0);
        checkOutput("clr/ready", in_ready_o, 1);
    endtask

    // Offers one sample, keeps in_valid_i high with junk during UPD/OUT to
    // show it is ignored there, and checks the strobe two edges after accept.
    task automatic applyStimulus(input int data, input int ch, input logic rnd,
                                 input string tag);
        int   expData;
        logic expFull;
        checkOutput({tag, "/readyIdle"}, in_ready_o, 1);
        in_valid_i = 1'b1;
        in_data_i  = data[7:0];
        in_ch_i    = ch[0:0];
        round_i    = rnd;
        @(posedge clk); #1;
        in_data_i = 8'($urandom);
        in_ch_i   = 1'($urandom);
        round_i   = 1'($urandom);
        hist[ch].push_back(data);
        expData = modelAverage(ch, rnd);
        expFull = modelFull(ch);
        checkOutput({tag, "/readyUpd"}, in_ready_o, 0);
        checkOutput({tag, "/validUpd"}, out_valid_o, 0);
        checkOutput({tag, "/holdUpd"}, out_data_o, lastData);
        @(posedge clk); #1;
        checkOutput({tag, "/validEarly"}, out_valid_o, 0);
        checkOutput({tag, "/readyOut"}, in_ready_o, 0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        checkOutput({tag, "/valid"}, out_valid_o, 1);
        checkOutput({tag, "/data"}, out_data_o, expData);
        checkOutput({tag, "/ch"}, out_ch_o, ch);
        checkOutput({tag, "/full"}, out_full_o, expFull);
        lastData = expData;
    endtask

    initial begin
        rst_n      = 1'b0;
        clear_i    = 1'b0;
        win_pow_i  = 2'd0;
        in_valid_i = 1'b0;
        in_data_i  = 8'd0;
        in_ch_i    = 1'b0;
        round_i    = 1'b0;
        sValid     = 1'b0;
        sData      = 8'd0;
        sCh        = 1'b0;
        sClear     = 1'b0;
        sWin       = 2'd0;
        sRound     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst/ready", in_ready_o, 1);
        checkOutput("rst/valid", out_valid_o, 0);
        checkOutput("rst/data", out_data_o, 0);
        checkOutput("rst/ch", out_ch_o, 0);
        checkOutput("rst/full", out_full_o, 0);
        rst_n = 1'b1;
        modelClear(WIN_POW_MAX);

        // Single-channel build: channel 1 does not exist and must be dropped.
        sValid = 1'b1;
        sCh    = 1'b1;
        sData  = 8'd200;
        @(posedge clk); #1;
        sValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bad/noStrobe", sOutValid, 0);
            @(posedge clk); #1;
        end
        checkOutput("bad/ready", sReady, 1);
        sValid = 1'b1;
        sCh    = 1'b0;
        sData  = 8'd4;
        @(posedge clk); #1;
        sValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bad/valid", sOutValid, 1);
        checkOutput("bad/data", sOutData, 1);

        // Warm-up with truncation at the reset window (2^2).
        applyStimulus(4, 0, 1'b0, "warm1");
        applyStimulus(8, 0, 1'b0, "warm2");
        applyStimulus(12, 0, 1'b0, "warm3");
        applyStimulus(16, 0, 1'b0, "warm4");
        applyStimulus(20, 0, 1'b0, "warm5");
        checkOutput("warm5/literal", out_data_o, 14);

        // Channel independence.
        doClear(2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(255, 0, 1'b0, "indep0");
            applyStimulus(0, 1, 1'b0, "indep1");
        end

        // Rounding, truncation and full-scale rounding at window 2^1.
        doClear(1);
        applyStimulus(3, 0, 1'b1, "rnd1");
        applyStimulus(4, 0, 1'b1, "rnd2");
        checkOutput("rnd2/literal", out_data_o, 4);
        doClear(1);
        applyStimulus(3, 0, 1'b0, "trunc1");
        applyStimulus(4, 0, 1'b0, "trunc2");
        checkOutput("trunc2/literal", out_data_o, 3);
        doClear(1);
        applyStimulus(255, 0, 1'b1, "sat1");
        applyStimulus(255, 0, 1'b1, "sat2");
        checkOutput("sat2/literal", out_data_o, 255);

        // Window request above the maximum is clamped.
        doClear(3);
        for (int i = 0; i < 4; i++) applyStimulus(8, 0, 1'b0, "clamp");
        checkOutput("clamp/literal", out_data_o, 8);

        // Clear while in UPD: the pending sample and its strobe vanish.
        applyStimulus(5, 1, 1'b0, "preClr");
        in_valid_i = 1'b1;
        in_data_i  = 8'd100;
        in_ch_i    = 1'b0;
        round_i    = 1'b0;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        clear_i    = 1'b1;
        win_pow_i  = 2'd2;
        @(posedge clk); #1;
        clear_i = 1'b0;
        modelClear(2);
        checkOutput("midClr/valid", out_valid_o, 0);
        checkOutput("midClr/data", out_data_o, 0);
        checkOutput("midClr/ch", out_ch_o, 0);
        checkOutput("midClr/ready", in_ready_o, 1);
        @(posedge clk); #1;
        checkOutput("midClr/noStrobe", out_valid_o, 0);
        applyStimulus(8, 0, 1'b0, "afterClr");
        checkOutput("afterClr/literal", out_data_o, 2);

        // Clear and valid on the same edge: sample is not accepted.
        in_valid_i = 1'b1;
        in_data_i  = 8'd77;
        clear_i    = 1'b1;
        win_pow_i  = 2'd2;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        clear_i    = 1'b0;
        modelClear(2);
        checkOutput("clrValid/ready", in_ready_o, 1);
        @(posedge clk); #1;
        checkOutput("clrValid/noStrobe1", out_valid_o, 0);
        @(posedge clk); #1;
        checkOutput("clrValid/noStrobe2", out_valid_o, 0);

        // Reset during OUT restores the reset window and discards history.
        doClear(1);
        applyStimulus(40, 0, 1'b0, "preRst");
        in_valid_i = 1'b1;
        in_data_i  = 8'd50;
        in_ch_i    = 1'b0;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        modelClear(WIN_POW_MAX);
        checkOutput("midRst/valid", out_valid_o, 0);
        checkOutput("midRst/data", out_data_o, 0);
        checkOutput("midRst/ready", in_ready_o, 1);
        applyStimulus(4, 0, 1'b0, "afterRst");
        checkOutput("afterRst/literal", out_data_o, 1);

        // Random traffic with occasional re-clears.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                doClear(int'($urandom_range(0, 3)));
            end else begin
                applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                              1'($urandom), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
